// File: rtl/pdm_fade_pkg.sv
// Shared definitions for the PDM fade controller:
// scan FSM encoding and index-width helper.
package pdm_fade_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_st_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pdm_fade_step.sv
// Combinational clamp/step unit: moves cur toward
// tgt by step without overshoot.
module pdm_fade_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt,
  output logic             reached
);

  logic [WIDTH:0] up;
  logic [WIDTH:0] gap;

  always_comb begin
    up  = {1'b0, cur} + {1'b0, step};
    gap = {1'b0, cur} - {1'b0, tgt};
    nxt = cur;
    if (step == '0) begin
      nxt = tgt;
    end else if (cur < tgt) begin
      nxt = (up >= {1'b0, tgt}) ? tgt : up[WIDTH-1:0];
    end else if (cur > tgt) begin
      nxt = ({1'b0, step} >= gap) ? tgt : cur - step;
    end
    reached = (cur != tgt) && (nxt == tgt);
  end

endmodule

// File: rtl/pdm_fade_ctrl.sv
// Multi-channel fade controller: per-channel ramps
// driven by a prescaler and a round-robin scan FSM.
module pdm_fade_ctrl
  import pdm_fade_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int WIDTH     = 8,
  parameter  int DIV_WIDTH = 16,
  localparam int IW        = idx_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 wr_stb,
  input  logic [IW-1:0]        wr_chan,
  input  logic [WIDTH-1:0]     wr_target,
  input  logic [WIDTH-1:0]     wr_step,
  output logic [NCH*WIDTH-1:0] val_out,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done_stb
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 tick;
  scan_st_e             state;
  logic [IW-1:0]        idx;
  logic                 pend;
  logic                 scan;
  logic                 last;

  logic [WIDTH-1:0] cur [NCH];
  logic [WIDTH-1:0] tgt [NCH];
  logic [WIDTH-1:0] stp [NCH];

  logic             wr_ok;
  logic             coll;
  logic [WIDTH-1:0] nxt;
  logic             reached;
  logic [NCH-1:0]   done_q;

  assign tick  = cfg_en && (cnt == '0);
  assign scan  = (state == S_SCAN);
  assign last  = (idx == IW'(NCH - 1));
  assign wr_ok = wr_stb && (32'(wr_chan) < NCH);
  assign coll  = wr_ok && scan && (wr_chan == idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cfg_en) begin
      cnt <= (cnt == '0) ? cfg_div : cnt - 1'b1;
    end
  end

  // A tick during a scan is held in pend; the last
  // scan cycle then chains straight into a new scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      pend  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (tick || pend) begin
            state <= S_SCAN;
            idx   <= '0;
            pend  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (last) begin
            idx <= '0;
            if (pend) begin
              pend <= 1'b0;
            end else begin
              state <= S_IDLE;
              pend  <= tick;
            end
          end else begin
            idx <= idx + 1'b1;
            if (tick) pend <= 1'b1;
          end
        end
      endcase
    end
  end

  pdm_fade_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .cur    (cur[idx]),
    .tgt    (tgt[idx]),
    .step   (stp[idx]),
    .nxt    (nxt),
    .reached(reached)
  );

  // A write to the channel under scan wins;
  // cur is then left alone for that pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
        stp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok && wr_chan == IW'(i)) begin
          tgt[i] <= wr_target;
          stp[i] <= wr_step;
        end else if (scan && idx == IW'(i)) begin
          cur[i] <= nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      done_q <= '0;
      if (scan && !coll && reached) begin
        done_q[idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    val_out = '0;
    busy    = '0;
    for (int i = 0; i < NCH; i++) begin
      val_out[i*WIDTH +: WIDTH] = cur[i];
      busy[i] = (cur[i] != tgt[i]);
    end
  end

  assign done_stb = done_q;

endmodule

// File: tb/tb_pdm_fade_ctrl.sv
// Self-checking bench for pdm_fade_ctrl: behavioural
// model plus directed and randomized stimulus.
module tb_pdm_fade_ctrl;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DW  = 16;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_en;
  logic [DW-1:0]    cfg_div;
  logic             wr_stb;
  logic [IW-1:0]    wr_chan;
  logic [W-1:0]     wr_target;
  logic [W-1:0]     wr_step;
  logic [NCH*W-1:0] val_out;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done_stb;

  pdm_fade_ctrl #(
    .NCH(NCH), .WIDTH(W), .DIV_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_div  (cfg_div),
    .wr_stb   (wr_stb),
    .wr_chan  (wr_chan),
    .wr_target(wr_target),
    .wr_step  (wr_step),
    .val_out  (val_out),
    .busy     (busy),
    .done_stb (done_stb)
  );

  always #5 clk = ~clk;

  int m_cur [NCH];
  int m_tgt [NCH];
  int m_stp [NCH];
  int m_cnt;
  int m_pos;
  int m_pend;
  logic [NCH-1:0] m_done;

  int n_chk = 0;
  int n_pass = 0;
  int hist [NCH][$];
  int dcnt [NCH];
  logic [W-1:0] prev [NCH];

  function automatic int ramp(int c, int t, int s);
    if (s == 0) return t;
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  task automatic timeout(string nm);
    n_chk++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; m_stp[i] = 0;
      prev[i] = '0;
    end
    m_cnt = 0; m_pos = -1; m_pend = 0; m_done = '0;
  endtask

  task automatic clr_hist();
    for (int i = 0; i < NCH; i++) begin
      hist[i].delete();
      dcnt[i] = 0;
    end
  endtask

  // One clock: predict from spec rules, advance, compare.
  task automatic cyc();
    int np, npd, nc, p, nv, wc, wt, ws2;
    bit tk, coll, dop, ws;
    logic [NCH-1:0] nd;
    logic [NCH*W-1:0] ev;
    logic [NCH-1:0] eb;
    ws = wr_stb; wc = int'(wr_chan);
    wt = int'(wr_target); ws2 = int'(wr_step);
    tk = cfg_en && (m_cnt == 0);
    nc = !cfg_en ? m_cnt
       : (m_cnt == 0 ? int'(cfg_div) : m_cnt - 1);
    p = m_pos; np = m_pos; npd = m_pend;
    if (p < 0) begin
      if (tk || m_pend != 0) begin np = 0; npd = 0; end
    end else if (p < NCH - 1) begin
      np = p + 1;
      if (tk) npd = 1;
    end else if (m_pend != 0) begin
      np = 0; npd = 0;
    end else begin
      np = -1; npd = tk ? 1 : 0;
    end
    coll = ws && wc < NCH && p >= 0 && wc == p;
    dop = (p >= 0) && !coll;
    nd = '0; nv = 0;
    if (dop) begin
      nv = ramp(m_cur[p], m_tgt[p], m_stp[p]);
      if (m_cur[p] != m_tgt[p] && nv == m_tgt[p])
        nd[p] = 1'b1;
    end
    @(posedge clk); #1;
    if (dop) m_cur[p] = nv;
    if (ws && wc < NCH) begin
      m_tgt[wc] = wt; m_stp[wc] = ws2;
    end
    m_cnt = nc; m_pos = np; m_pend = npd; m_done = nd;
    for (int i = 0; i < NCH; i++) begin
      ev[i*W +: W] = W'(m_cur[i]);
      eb[i] = (m_cur[i] != m_tgt[i]);
    end
    check("val_out", val_out, ev);
    check("busy", busy, eb);
    check("done_stb", done_stb, m_done);
    for (int i = 0; i < NCH; i++) begin
      if (val_out[i*W +: W] != prev[i])
        hist[i].push_back(int'(val_out[i*W +: W]));
      prev[i] = val_out[i*W +: W];
      dcnt[i] += int'(done_stb[i]);
    end
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int ch, int t, int s);
    wr_stb = 1'b1; wr_chan = IW'(ch);
    wr_target = W'(t); wr_step = W'(s);
    cyc();
    wr_stb = 1'b0;
  endtask

  task automatic wait_pos(int p, int lim);
    int k = 0;
    while (m_pos != p && k < lim) begin cyc(); k++; end
    if (m_pos != p) timeout("wait_scan_pos");
  endtask

  task automatic wait_idle(int lim);
    int k = 0;
    while ((m_pos >= 0 || m_pend != 0) && k < lim) begin
      cyc(); k++;
    end
    if (m_pos >= 0 || m_pend != 0) timeout("wait_idle");
  endtask

  task automatic chk_hist(string nm, int ch, int n,
                          int e0, int e1, int e2, int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({nm, "_len"}, hist[ch].size(), n);
    for (int i = 0; i < n && i < hist[ch].size(); i++)
      check({nm, "_val"}, hist[ch][i], e[i]);
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = '0;
    wr_stb = 1'b0; wr_chan = '0;
    wr_target = '0; wr_step = '0;
    model_reset();
    clr_hist();
    repeat (2) @(posedge clk);
    #1;
    check("rst_val", val_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_stb, 0);
    #2 rst_n = 1'b1;

    // ramp up ch0
    cfg_div = DW'(9);
    wr(0, 8'h40, 8'h10);
    check("ramp_busy0", busy[0], 1);
    clr_hist();
    cfg_en = 1'b1;
    run(45);
    chk_hist("ramp0", 0, 4, 8'h10, 8'h20, 8'h30, 8'h40);
    check("ramp0_done", dcnt[0], 1);
    check("ramp0_idle", busy[0], 0);

    // clamp and down ramp on ch1
    clr_hist();
    wr(1, 8'h25, 8'h10);
    run(40);
    chk_hist("clamp1", 1, 3, 8'h10, 8'h20, 8'h25, 0);
    clr_hist();
    wr(1, 8'h00, 8'h10);
    run(40);
    chk_hist("down1", 1, 3, 8'h15, 8'h05, 8'h00, 0);
    clr_hist();
    wr(1, 8'hFF, 8'h80);
    run(40);
    chk_hist("nowrap1", 1, 2, 8'h80, 8'hFF, 0, 0);

    // jump on ch2, then write target == cur
    clr_hist();
    wr(2, 8'hAA, 8'h00);
    run(12);
    chk_hist("jump2", 2, 1, 8'hAA, 0, 0, 0);
    check("jump2_done", dcnt[2], 1);
    cfg_en = 1'b0;
    wait_idle(64);
    wr(2, 8'h50, 8'h01);
    check("eq2_busy_set", busy[2], 1);
    clr_hist();
    wr(2, 8'hAA, 8'h00);
    check("eq2_busy_clr", busy[2], 0);
    run(5);
    check("eq2_nodone", dcnt[2], 0);

    // collision on ch3
    wr(3, 8'h80, 8'h20);
    cfg_en = 1'b1;
    wait_pos(3, 64);
    cyc();
    check("coll3_pre", val_out[3*W +: W], 8'h20);
    wait_pos(3, 64);
    clr_hist();
    wr(3, 8'h10, 8'h01);
    check("coll3_cur", val_out[3*W +: W], 8'h20);
    check("coll3_busy", busy[3], 1);
    check("coll3_done", dcnt[3], 0);

    // randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      cfg_div = DW'($urandom_range(0, 12));
      for (int k = 0; k < 200; k++) begin
        cfg_en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 3) == 0) begin
          wr_stb = 1'b1;
          wr_chan = IW'($urandom_range(0, NCH - 1));
          wr_target = W'($urandom);
          wr_step = ($urandom_range(0, 7) == 0)
                  ? '0 : W'($urandom_range(1, 64));
        end
        cyc();
        wr_stb = 1'b0;
      end
    end

    // asynchronous reset in the middle of a scan
    for (int i = 0; i < NCH; i++) wr(i, 8'hF0, 8'h30);
    cfg_en = 1'b1; cfg_div = DW'(9);
    wait_pos(1, 64);
    #3 rst_n = 1'b0;
    #1;
    check("arst_val", val_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done_stb, 0);
    model_reset();
    cfg_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // back-to-back scans through the pending tick
    for (int i = 0; i < NCH; i++) wr(i, 8'hFF, 8'h01);
    cfg_div = DW'(2);
    cfg_en = 1'b1;
    run(40);
    check("pend_vals", val_out, 32'h090A0A0A);
    cfg_en = 1'b0;
    run(20);
    check("freeze_vals", val_out, 32'h0B0B0B0B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
